// File: rtl/memory_pkg.sv
// Shared types, legality checks and the byte-merge helper for the memory_dp macro.
package memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_e;

    localparam int BYTE_W         = 8;
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic bit data_width_ok(input int dw);
        return (dw >= BYTE_W) && (dw % BYTE_W == 0);
    endfunction

    function automatic bit rd_latency_ok(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

    // Byte-lane merge: take the incoming byte only when its enable is set.
    function automatic logic [BYTE_W-1:0] be_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/memory_dp_if.sv
// Write/read/clear port bundle of the memory_dp storage macro.
interface memory_dp_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    clear_req;
    logic                    busy;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;

    modport master (
        output clear_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clear_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/memory_rd_pipe.sv
// Read-result pipeline: LATENCY valid/data stages; data only moves with valid so
// the output word holds between results.
module memory_rd_pipe #(
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic                  valid_reg;
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  valid_next;
        logic [DATA_WIDTH-1:0] data_next;

        if (gi == 0) begin : g_src
            assign valid_next = in_valid;
            assign data_next  = in_data;
        end else begin : g_src
            assign valid_next = g_stage[gi-1].valid_reg;
            assign data_next  = g_stage[gi-1].data_reg;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= valid_next;
                if (valid_next) begin
                    data_reg <= data_next;
                end
            end
        end
    end

    assign out_valid = g_stage[LATENCY-1].valid_reg;
    assign out_data  = g_stage[LATENCY-1].data_reg;

endmodule

// File: rtl/memory_dp.sv
// Simple-dual-port memory with byte enables, 1/2-cycle read latency, selectable
// collision behaviour and a sequential clear engine run after reset or on request.
module memory_dp
    import memory_pkg::*;
#(
    parameter int                        ADDR_WIDTH  = 8,
    parameter int                        DATA_WIDTH  = 32,
    parameter int                        RD_LATENCY  = 1,
    parameter int                        WRITE_FIRST = 1,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE = '0
) (
    input  logic      clk,
    input  logic      reset_n,
    memory_dp_if.slave bus
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / BYTE_W;

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("memory_dp: DATA_WIDTH must be a positive multiple of 8");
    end
    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("memory_dp: RD_LATENCY must be 1 or 2");
    end

    mem_state_e            state_reg;
    logic [ADDR_WIDTH-1:0] clr_cnt_reg;
    logic                  busy_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (&clr_cnt_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        state_reg   <= ST_CLEAR;
                        clr_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_CLEAR;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;

    logic wr_acc;
    logic rd_acc;
    logic fwd_new;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_acc  = bus.wr_en & ~busy_reg;
    assign rd_acc  = bus.rd_en & ~busy_reg;
    // Bypass the merged write word into the read only in write-first mode.
    assign fwd_new = (WRITE_FIRST != 0) && wr_acc && rd_acc && (bus.wr_addr == bus.rd_addr);

    // One byte-wide array per lane keeps byte enables as plain lane write strobes.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        logic [BYTE_W-1:0] lane_mem [DEPTH];
        logic [BYTE_W-1:0] old_byte;

        always_ff @(posedge clk) begin
            if (busy_reg) begin
                lane_mem[clr_cnt_reg] <= CLEAR_VALUE[BYTE_W*gi +: BYTE_W];
            end else if (wr_acc && bus.wr_be[gi]) begin
                lane_mem[bus.wr_addr] <= bus.wr_data[BYTE_W*gi +: BYTE_W];
            end
        end

        assign old_byte = lane_mem[bus.rd_addr];
        assign rd_word[BYTE_W*gi +: BYTE_W] =
            fwd_new ? be_merge(old_byte, bus.wr_data[BYTE_W*gi +: BYTE_W], bus.wr_be[gi])
                    : old_byte;
    end

    memory_rd_pipe #(
        .LATENCY    (RD_LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (bus.rd_valid),
        .out_data  (bus.rd_data)
    );

endmodule

// File: tb/tb_memory_dp.sv
// Two memory_dp configurations driven in lockstep and checked against a
// cycle-scheduled behavioural model.
module tb_memory_dp;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV0   = 32'hDEAD_BEEF;
    localparam logic [31:0] CV1   = 32'h5A5A_0F0F;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    memory_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
    memory_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

    memory_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .WRITE_FIRST(1),
                .CLEAR_VALUE(CV0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    memory_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .WRITE_FIRST(0),
                .CLEAR_VALUE(CV1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [31:0] mem_m  [2][DEPTH];
    int          rem    [2];
    logic        slot_v [2][4];
    logic [31:0] slot_d [2][4];
    logic [31:0] last_d [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] cv_of(input int d);
        return (d == 0) ? CV0 : CV1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_busy(input int d);
        return {31'd0, (d == 0) ? if_a.busy : if_b.busy};
    endfunction
    function automatic logic [31:0] dut_valid(input int d);
        return {31'd0, (d == 0) ? if_a.rd_valid : if_b.rd_valid};
    endfunction
    function automatic logic [31:0] dut_data(input int d);
        return (d == 0) ? if_a.rd_data : if_b.rd_data;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rem[d]    = DEPTH;
            last_d[d] = '0;
            for (int s = 0; s < 4; s++) slot_v[d][s] = 1'b0;
            for (int a = 0; a < DEPTH; a++) mem_m[d][a] = cv_of(d);
        end
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("dut%0d.rst_busy", d), dut_busy(d), 32'd1);
            check_eq($sformatf("dut%0d.rst_valid", d), dut_valid(d), 32'd0);
            check_eq($sformatf("dut%0d.rst_data", d), dut_data(d), 32'd0);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check all outputs.
    task automatic cycle(input logic c, input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic re, input logic [3:0] ra);
        logic [31:0] rd;
        if_a.clear_req = c;  if_b.clear_req = c;
        if_a.wr_en = we;     if_b.wr_en = we;
        if_a.wr_addr = wa;   if_b.wr_addr = wa;
        if_a.wr_data = wd;   if_b.wr_data = wd;
        if_a.wr_be = be;     if_b.wr_be = be;
        if_a.rd_en = re;     if_b.rd_en = re;
        if_a.rd_addr = ra;   if_b.rd_addr = ra;
        for (int d = 0; d < 2; d++) begin
            if (rem[d] > 0) begin
                rem[d]--;
            end else begin
                if (re) begin
                    rd = mem_m[d][ra];
                    if (d == 0 && we && wa == ra) rd = merge(rd, wd, be);
                    slot_v[d][(cyc + lat_of(d)) % 4] = 1'b1;
                    slot_d[d][(cyc + lat_of(d)) % 4] = rd;
                end
                if (we) mem_m[d][wa] = merge(mem_m[d][wa], wd, be);
                if (c) begin
                    rem[d] = DEPTH;
                    for (int a = 0; a < DEPTH; a++) mem_m[d][a] = cv_of(d);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (slot_v[d][cyc % 4]) last_d[d] = slot_d[d][cyc % 4];
            check_eq($sformatf("dut%0d.busy", d), dut_busy(d), {31'd0, rem[d] > 0});
            check_eq($sformatf("dut%0d.rd_valid", d), dut_valid(d), {31'd0, slot_v[d][cyc % 4]});
            check_eq($sformatf("dut%0d.rd_data", d), dut_data(d), last_d[d]);
            slot_v[d][cyc % 4] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v, input logic [3:0] be);
        cycle(0, 1, a, v, be, 0, '0);
    endtask

    task automatic rd_all();
        for (int a = 0; a < DEPTH; a++) cycle(0, 0, '0, '0, '0, 1, 4'(a));
        idle(3);
    endtask

    initial begin
        if_a.clear_req = 0; if_b.clear_req = 0;
        if_a.wr_en = 0; if_b.wr_en = 0; if_a.rd_en = 0; if_b.rd_en = 0;
        if_a.wr_addr = '0; if_b.wr_addr = '0; if_a.wr_data = '0; if_b.wr_data = '0;
        if_a.wr_be = '0; if_b.wr_be = '0; if_a.rd_addr = '0; if_b.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_reset_outputs();
        reset_n = 1'b1;

        // Power-up sweep, then every location holds the clear value
        idle(DEPTH + 1);
        rd_all();

        // Byte-enable merge on address 3
        wr(4'd3, 32'h1122_3344, 4'hF);
        wr(4'd3, 32'hAABB_CCDD, 4'b0101);
        cycle(0, 0, '0, '0, '0, 1, 4'd3);
        idle(3);

        // Back-to-back reads of preloaded 5,6,7
        wr(4'd5, 32'h0000_0005, 4'hF);
        wr(4'd6, 32'h0000_0006, 4'hF);
        wr(4'd7, 32'h0000_0007, 4'hF);
        for (int a = 5; a <= 7; a++) cycle(0, 0, '0, '0, '0, 1, 4'(a));
        idle(3);

        // Read-during-write collision on address 9
        wr(4'd9, 32'h0, 4'hF);
        cycle(0, 1, 4'd9, 32'hFFFF_FFFF, 4'h3, 1, 4'd9);
        idle(3);

        // Randomised traffic with occasional clear requests
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 63) == 0, 1'($urandom), 4'($urandom), $urandom,
                  4'($urandom), 1'($urandom), 4'($urandom));
        idle(DEPTH + 3);

        // Clear after fill, with traffic blocked during the sweep
        for (int a = 0; a < DEPTH; a++) wr(4'(a), $urandom, 4'hF);
        cycle(1, 0, '0, '0, '0, 1, 4'd2);
        for (int i = 0; i < DEPTH; i++)
            cycle(1'($urandom), 1, 4'($urandom), $urandom, 4'hF, 1, 4'($urandom));
        idle(2);
        rd_all();

        // Reset asserted while the clear counter sits at 7
        for (int a = 0; a < DEPTH; a++) wr(4'(a), $urandom, 4'hF);
        cycle(0, 0, '0, '0, '0, 1, 4'd4);
        cycle(1, 0, '0, '0, '0, 1, 4'd5);
        idle(7);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        #2 reset_n = 1'b1;
        idle(DEPTH + 1);
        rd_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
